// File: rtl/lc3_controller_if.sv
// Bus between the LC3 datapath and lc3_controller: decode/execute words, memory
// handshakes and condition codes in; stage enables, branch and forward selects out.
interface lc3_controller_if;
    logic        complete_data;
    logic        complete_instr;
    logic [15:0] IR;
    logic [15:0] IR_Exec;
    logic [15:0] IMem_dout;
    logic [2:0]  NZP;
    logic [2:0]  psr;

    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        br_taken;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic [1:0]  mem_state;

    modport master (
        output complete_data, complete_instr, IR, IR_Exec, IMem_dout, NZP, psr,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_state
    );

    modport slave (
        input  complete_data, complete_instr, IR, IR_Exec, IMem_dout, NZP, psr,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, mem_state
    );
endinterface

// File: rtl/lc3_controller.sv
// LC3 pipeline control: fill sequencing, memory FSM, branch bubbles and stalls.
// Operand forwarding is built only when LC3_CTRL_BYPASS_EN is defined.
module lc3_controller #(
    parameter int BR_BUBBLES = 3
) (
    input  logic             clock,
    input  logic             reset,
    lc3_controller_if.slave  ctl
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam int BUBBLE_W = (BR_BUBBLES < 1) ? 1 : $clog2(BR_BUBBLES + 1);
    localparam logic [BUBBLE_W-1:0] BUBBLE_LOAD = BUBBLE_W'(BR_BUBBLES);

    typedef enum logic [1:0] {
        MEM_RD   = 2'd0,
        MEM_IND  = 2'd1,
        MEM_WR   = 2'd2,
        MEM_IDLE = 2'd3
    } mem_state_t;

    logic [3:0]          op_dec;
    logic [3:0]          op_exec;
    mem_state_t          mem_state_q;
    mem_state_t          mem_state_d;
    logic [2:0]          fill_q;
    logic [2:0]          fill_d;
    logic [BUBBLE_W-1:0] bubble_q;
    logic [BUBBLE_W-1:0] bubble_d;
    logic                mem_stall;
    logic                rd_commit;
    logic                front_ok;

    assign op_dec  = ctl.IR[15:12];
    assign op_exec = ctl.IR_Exec[15:12];

    // Memory access sequencing; a new access is accepted only from IDLE while execute runs.
    always_comb begin
        mem_state_d = mem_state_q;
        case (mem_state_q)
            MEM_IDLE: begin
                if (ctl.enable_execute) begin
                    case (op_exec)
                        OP_LD, OP_LDR:  mem_state_d = MEM_RD;
                        OP_LDI, OP_STI: mem_state_d = MEM_IND;
                        OP_ST, OP_STR:  mem_state_d = MEM_WR;
                        default:        mem_state_d = MEM_IDLE;
                    endcase
                end
            end
            MEM_IND: begin
                if (ctl.complete_data)
                    mem_state_d = (op_exec == OP_STI) ? MEM_WR : MEM_RD;
            end
            MEM_RD, MEM_WR: begin
                if (ctl.complete_data)
                    mem_state_d = MEM_IDLE;
            end
            default: mem_state_d = MEM_IDLE;
        endcase
    end

    // The bubble count is frozen while a data access is outstanding so the branch
    // still gets its full shadow once the pipeline resumes.
    always_comb begin
        bubble_d = bubble_q;
        if (ctl.enable_decode && (op_dec == OP_BR || op_dec == OP_JMP))
            bubble_d = BUBBLE_LOAD;
        else if (bubble_q != '0 && mem_state_q == MEM_IDLE)
            bubble_d = bubble_q - 1'b1;
    end

    assign fill_d    = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
    assign mem_stall = (mem_state_d != MEM_IDLE);
    assign rd_commit = (mem_state_q == MEM_RD) && ctl.complete_data;
    assign front_ok  = !mem_stall && ctl.complete_instr && (bubble_d == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_state_q          <= MEM_IDLE;
            fill_q               <= 3'd0;
            bubble_q             <= '0;
            ctl.enable_updatePC  <= 1'b0;
            ctl.enable_fetch     <= 1'b0;
            ctl.enable_decode    <= 1'b0;
            ctl.enable_execute   <= 1'b0;
            ctl.enable_writeback <= 1'b0;
        end else begin
            mem_state_q          <= mem_state_d;
            fill_q               <= fill_d;
            bubble_q             <= bubble_d;
            ctl.enable_updatePC  <= (fill_d >= 3'd1) && front_ok;
            ctl.enable_fetch     <= (fill_d >= 3'd1) && front_ok;
            ctl.enable_decode    <= (fill_d >= 3'd2) && front_ok;
            ctl.enable_execute   <= (fill_d >= 3'd3) && !mem_stall;
            ctl.enable_writeback <= ((fill_d >= 3'd4) && !mem_stall) || rd_commit;
        end
    end

    assign ctl.mem_state = mem_state_q;

    assign ctl.br_taken = ctl.enable_execute &&
                          (((op_exec == OP_BR) && |(ctl.NZP & ctl.psr)) ||
                           (op_exec == OP_JMP));

`ifdef LC3_CTRL_BYPASS_EN
    logic dec_alu;
    logic exec_alu;
    logic dec_store;
    logic sr1_hit;
    logic sr2_hit;
    logic sr_hit;

    assign dec_alu   = (op_dec == OP_ADD) || (op_dec == OP_AND) || (op_dec == OP_NOT);
    assign exec_alu  = (op_exec == OP_ADD) || (op_exec == OP_AND) || (op_exec == OP_NOT);
    assign dec_store = (op_dec == OP_ST) || (op_dec == OP_STR) || (op_dec == OP_STI);
    assign sr1_hit   = (ctl.IR[8:6] == ctl.IR_Exec[11:9]);
    assign sr2_hit   = (ctl.IR[2:0] == ctl.IR_Exec[11:9]);
    assign sr_hit    = (ctl.IR[11:9] == ctl.IR_Exec[11:9]);

    // Second ALU operand is a register only in register-mode ADD/AND.
    assign ctl.bypass_alu_1 = !reset && dec_alu && exec_alu && sr1_hit;
    assign ctl.bypass_alu_2 = !reset && dec_alu && exec_alu && sr2_hit &&
                              !ctl.IR[5] && (op_dec != OP_NOT);
    assign ctl.bypass_mem_1 = !reset && dec_store && exec_alu && sr1_hit;
    assign ctl.bypass_mem_2 = !reset && dec_store && exec_alu && sr_hit;
`else
    assign ctl.bypass_alu_1 = 1'b0;
    assign ctl.bypass_alu_2 = 1'b0;
    assign ctl.bypass_mem_1 = 1'b0;
    assign ctl.bypass_mem_2 = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_controller.sv
// Directed bench for lc3_controller: combinational decode table plus fill, stall,
// branch-bubble, LDI and reset-mid-access sequences.
module tb_lc3_controller;

`ifdef LC3_CTRL_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    lc3_controller_if bus ();

    lc3_controller #(.BR_BUBBLES(3)) dut (
        .clock (clock),
        .reset (reset),
        .ctl   (bus.slave)
    );

    logic [4:0] en;
    logic [4:0] comb_out;
    assign en = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                 bus.enable_execute, bus.enable_writeback};
    assign comb_out = {bus.br_taken, bus.bypass_alu_1, bus.bypass_alu_2,
                       bus.bypass_mem_1, bus.bypass_mem_2};

    typedef struct {
        logic [15:0] ir;
        logic [15:0] ir_exec;
        logic [2:0]  nzp;
        logic [2:0]  psr;
        logic        br;
        logic [3:0]  byp;
    } vec_t;

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [15:0] ir, input logic [15:0] ir_exec,
                                  input logic [2:0] nzp, input logic [2:0] psr,
                                  input logic cd, input logic ci);
        bus.IR             = ir;
        bus.IR_Exec        = ir_exec;
        bus.NZP            = nzp;
        bus.psr            = psr;
        bus.complete_data  = cd;
        bus.complete_instr = ci;
    endtask

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic check_regs(input string name, input logic [4:0] exp_en,
                              input logic [1:0] exp_mem);
        check_output({name, " enables"}, {11'd0, en}, {11'd0, exp_en});
        check_output({name, " mem_state"}, {14'd0, bus.mem_state}, {14'd0, exp_mem});
    endtask

    vec_t vecs[12];

    initial begin
        checks   = 0;
        failures = 0;
        clock    = 1'b0;
        reset    = 1'b1;
        bus.IMem_dout = 16'h0000;

        // {IR, IR_Exec, NZP, psr, br_taken, {alu1, alu2, mem1, mem2}}
        vecs[0]  = '{16'h1200, 16'h1042, 3'b000, 3'b000, 1'b0, 4'b1100};
        vecs[1]  = '{16'h76C1, 16'h5660, 3'b000, 3'b000, 1'b0, 4'b0011};
        vecs[2]  = '{16'h1220, 16'h1042, 3'b000, 3'b000, 1'b0, 4'b1000};
        vecs[3]  = '{16'h903F, 16'h1042, 3'b000, 3'b000, 1'b0, 4'b1000};
        vecs[4]  = '{16'h1042, 16'h5660, 3'b000, 3'b000, 1'b0, 4'b0000};
        vecs[5]  = '{16'h1283, 16'h5660, 3'b000, 3'b000, 1'b0, 4'b0100};
        vecs[6]  = '{16'h3600, 16'h5660, 3'b000, 3'b000, 1'b0, 4'b0001};
        vecs[7]  = '{16'h7000, 16'hE000, 3'b000, 3'b000, 1'b0, 4'b0000};
        vecs[8]  = '{16'h1000, 16'h0E05, 3'b010, 3'b111, 1'b1, 4'b0000};
        vecs[9]  = '{16'h1000, 16'h0E05, 3'b100, 3'b010, 1'b0, 4'b0000};
        vecs[10] = '{16'h1000, 16'hC1C0, 3'b000, 3'b000, 1'b1, 4'b0000};
        vecs[11] = '{16'h1000, 16'h0E05, 3'b001, 3'b001, 1'b1, 4'b0000};

        // Reset held two cycles with an ALU hazard pattern on the bus.
        apply_stimulus(16'h1200, 16'h1042, 3'b000, 3'b000, 1'b0, 1'b1);
        step();
        step();
        check_regs("reset", 5'b00000, 2'd3);
        check_output("reset comb", {11'd0, comb_out}, 16'd0);

        // Fill sequence.
        reset = 1'b0;
        step();
        check_regs("fill1", 5'b11000, 2'd3);
        step();
        check_regs("fill2", 5'b11100, 2'd3);
        step();
        check_regs("fill3", 5'b11110, 2'd3);
        step();
        check_regs("fill4", 5'b11111, 2'd3);

        // Combinational decode table in steady state.
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].ir, vecs[i].ir_exec, vecs[i].nzp, vecs[i].psr, 1'b0, 1'b1);
            #1;
            check_output($sformatf("vec%0d comb", i), {11'd0, comb_out},
                         {11'd0, vecs[i].br, vecs[i].byp & {4{BYP}}});
            step();
            check_output($sformatf("vec%0d enables", i), {11'd0, en}, 16'h001F);
        end

        // Instruction-memory stall for two cycles.
        apply_stimulus(16'h1000, 16'h1000, 3'b000, 3'b000, 1'b0, 1'b0);
        step();
        check_regs("istall1", 5'b00011, 2'd3);
        step();
        check_regs("istall2", 5'b00011, 2'd3);
        bus.complete_instr = 1'b1;
        step();
        check_regs("istall end", 5'b11111, 2'd3);

        // BR enters decode: three bubbles in front, branch resolves in execute.
        bus.IR = 16'h0E05;
        step();
        check_regs("br bubble1", 5'b00011, 2'd3);
        apply_stimulus(16'h1000, 16'h0E05, 3'b010, 3'b111, 1'b0, 1'b1);
        #1;
        check_output("br taken", {15'd0, bus.br_taken}, 16'd1);
        step();
        check_regs("br bubble2", 5'b00011, 2'd3);
        apply_stimulus(16'h1000, 16'h0E05, 3'b100, 3'b010, 1'b0, 1'b1);
        #1;
        check_output("br not taken", {15'd0, bus.br_taken}, 16'd0);
        step();
        check_regs("br bubble3", 5'b00011, 2'd3);
        bus.IR_Exec = 16'h1000;
        step();
        check_regs("br resume", 5'b11111, 2'd3);

        // LDI: IDLE -> IND -> RD -> IDLE, completion two cycles into each state.
        bus.IR_Exec = 16'hA201;
        step();
        check_regs("ldi ind1", 5'b00000, 2'd1);
        step();
        check_regs("ldi ind2", 5'b00000, 2'd1);
        bus.complete_data = 1'b1;
        step();
        bus.complete_data = 1'b0;
        check_regs("ldi rd1", 5'b00000, 2'd0);
        step();
        check_regs("ldi rd2", 5'b00000, 2'd0);
        bus.complete_data = 1'b1;
        step();
        bus.complete_data = 1'b0;
        bus.IR_Exec = 16'h1000;
        check_regs("ldi commit", 5'b11111, 2'd3);
        step();
        check_regs("ldi after", 5'b11111, 2'd3);

        // BR in decode and LD entering memory together: bubbles wait for the load.
        bus.IR      = 16'h0E05;
        bus.IR_Exec = 16'h2000;
        step();
        bus.IR = 16'h1000;
        check_regs("brld rd1", 5'b00000, 2'd0);
        step();
        check_regs("brld rd2", 5'b00000, 2'd0);
        bus.complete_data = 1'b1;
        step();
        bus.complete_data = 1'b0;
        bus.IR_Exec = 16'h1000;
        check_regs("brld bubble1", 5'b00011, 2'd3);
        step();
        check_regs("brld bubble2", 5'b00011, 2'd3);
        step();
        check_regs("brld bubble3", 5'b00011, 2'd3);
        step();
        check_regs("brld resume", 5'b11111, 2'd3);

        // Reset during a store restarts the fill.
        bus.IR_Exec = 16'h3000;
        step();
        check_regs("st wr", 5'b00000, 2'd2);
        reset = 1'b1;
        step();
        check_regs("mid reset", 5'b00000, 2'd3);
        reset = 1'b0;
        bus.IR_Exec = 16'h1000;
        step();
        check_regs("refill1", 5'b11000, 2'd3);
        step();
        check_regs("refill2", 5'b11100, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
